// File: rtl/sonic_fft_pkg.sv
// Shared types and helpers for the FFT post-processing blocks.
package sonic_fft_pkg;

    localparam int unsigned FFT_SIZE_DEFAULT = 1024;

    typedef logic [31:0] fft_mag_t;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } fft_cplx_t;

    function automatic int bin_width(int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fft_peak_bin_finder_if.sv
// FFT sample stream in, peak result out. With PEAK_NOISE_GATE_EN defined
// the bundle also carries peak_found_out.
interface fft_peak_bin_finder_if
    import sonic_fft_pkg::*;
#(
    parameter int unsigned BinW = 10
);
    logic            fft_ce_in;
    logic            fft_sync_in;
    logic [31:0]     fft_result_in;
    logic            peak_valid_out;
    logic [BinW-1:0] peak_bin_out;
    fft_mag_t        peak_mag_out;
    logic            frame_err_out;
`ifdef PEAK_NOISE_GATE_EN
    logic            peak_found_out;

    modport master (
        output fft_ce_in, fft_sync_in, fft_result_in,
        input  peak_valid_out, peak_bin_out, peak_mag_out, frame_err_out, peak_found_out
    );
    modport slave (
        input  fft_ce_in, fft_sync_in, fft_result_in,
        output peak_valid_out, peak_bin_out, peak_mag_out, frame_err_out, peak_found_out
    );
`else
    modport master (
        output fft_ce_in, fft_sync_in, fft_result_in,
        input  peak_valid_out, peak_bin_out, peak_mag_out, frame_err_out
    );
    modport slave (
        input  fft_ce_in, fft_sync_in, fft_result_in,
        output peak_valid_out, peak_bin_out, peak_mag_out, frame_err_out
    );
`endif
endinterface

// File: rtl/fft_mag_sq.sv
// Registered squared-magnitude stage; bin index and last flag ride along as sideband.
module fft_mag_sq
    import sonic_fft_pkg::*;
#(
    parameter int unsigned BinW = 10
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            valid_in,
    input  fft_cplx_t       cplx_in,
    input  logic [BinW-1:0] bin_in,
    input  logic            last_in,
    output logic            valid_out,
    output fft_mag_t        mag_out,
    output logic [BinW-1:0] bin_out,
    output logic            last_out
);
    logic signed [31:0] re_ext, im_ext, sq_re, sq_im;
    fft_mag_t           mag_d;

    // Each square is at most 2^30, so the 32-bit unsigned sum cannot wrap.
    always_comb begin
        re_ext = $signed({{16{cplx_in.re[15]}}, cplx_in.re});
        im_ext = $signed({{16{cplx_in.im[15]}}, cplx_in.im});
        sq_re  = re_ext * re_ext;
        sq_im  = im_ext * im_ext;
        mag_d  = $unsigned(sq_re) + $unsigned(sq_im);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_out <= 1'b0;
            mag_out   <= '0;
            bin_out   <= '0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= valid_in;
            mag_out   <= mag_d;
            bin_out   <= bin_in;
            last_out  <= last_in;
        end
    end

endmodule

// File: rtl/fft_peak_bin_finder.sv
// Streaming peak-bin detector over a bin window of each FFT frame.
// Optional noise gate enabled by defining PEAK_NOISE_GATE_EN.
module fft_peak_bin_finder
    import sonic_fft_pkg::*;
#(
    parameter int unsigned FFT_SIZE     = FFT_SIZE_DEFAULT,
    parameter int unsigned MIN_BIN      = 1,
    parameter int unsigned MAX_BIN      = FFT_SIZE / 2 - 1
`ifdef PEAK_NOISE_GATE_EN
    ,
    parameter int unsigned MIN_PEAK_MAG = 1024
`endif
) (
    input logic                  clk_in,
    input logic                  rst_in,
    fft_peak_bin_finder_if.slave bus
);
    localparam int BinW = bin_width(FFT_SIZE);
    localparam logic [BinW-1:0] LastBin = BinW'(FFT_SIZE - 1);
    localparam logic [BinW-1:0] MinBin  = BinW'(MIN_BIN);
    localparam logic [BinW-1:0] MaxBin  = BinW'(MAX_BIN);

    typedef enum logic [0:0] {StWaitSync, StAccum} state_e;

    state_e          state_q, state_d;
    logic [BinW-1:0] cnt_q, cnt_d;
    logic            accept, s0_last, err_d;
    logic [BinW-1:0] s0_bin;

    logic            s1_valid, s1_last;
    logic [BinW-1:0] s1_bin;
    fft_mag_t        s1_mag;

    fft_mag_t        max_q, max_d;
    logic [BinW-1:0] max_bin_q, max_bin_d;
    logic            upd, done;

    logic            peak_valid_q, frame_err_q;
    logic [BinW-1:0] peak_bin_q;
    fft_mag_t        peak_mag_q;

    // A sync inside a frame always arrives before the last bin (the last bin
    // returns to StWaitSync), so it is always an early sync.
    always_comb begin
        accept  = 1'b0;
        err_d   = 1'b0;
        s0_bin  = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StWaitSync: begin
                if (bus.fft_ce_in && bus.fft_sync_in) accept = 1'b1;
            end
            StAccum: begin
                if (bus.fft_ce_in) begin
                    accept = 1'b1;
                    if (bus.fft_sync_in) err_d = 1'b1;
                    else                 s0_bin = cnt_q + 1'b1;
                end
            end
            default: state_d = StWaitSync;
        endcase
        s0_last = accept && (s0_bin == LastBin);
        if (accept) begin
            cnt_d   = s0_bin;
            state_d = s0_last ? StWaitSync : StAccum;
        end
    end

    fft_mag_sq #(
        .BinW (BinW)
    ) u_mag_sq (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (accept),
        .cplx_in   (fft_cplx_t'(bus.fft_result_in)),
        .bin_in    (s0_bin),
        .last_in   (s0_last),
        .valid_out (s1_valid),
        .mag_out   (s1_mag),
        .bin_out   (s1_bin),
        .last_out  (s1_last)
    );

    // The first in-window bin reloads the max, which also discards any partial frame.
    always_comb begin
        upd       = s1_valid && (s1_bin >= MinBin) && (s1_bin <= MaxBin) &&
                    ((s1_bin == MinBin) || (s1_mag > max_q));
        max_d     = upd ? s1_mag : max_q;
        max_bin_d = upd ? s1_bin : max_bin_q;
        done      = s1_valid && s1_last;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= StWaitSync;
            cnt_q        <= '0;
            max_q        <= '0;
            max_bin_q    <= '0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            max_bin_q    <= max_bin_d;
            peak_valid_q <= done;
            frame_err_q  <= err_d;
            if (done) begin
                peak_bin_q <= max_bin_d;
                peak_mag_q <= max_d;
            end
        end
    end

`ifdef PEAK_NOISE_GATE_EN
    logic peak_found_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in)   peak_found_q <= 1'b0;
        else if (done) peak_found_q <= (max_d >= fft_mag_t'(MIN_PEAK_MAG));
    end

    assign bus.peak_found_out = peak_found_q;
`endif

    assign bus.peak_valid_out = peak_valid_q;
    assign bus.peak_bin_out   = peak_bin_q;
    assign bus.peak_mag_out   = peak_mag_q;
    assign bus.frame_err_out  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_bin_finder.sv
// Scoreboard bench for fft_peak_bin_finder with FFT_SIZE=64, window 1..31.
module tb_fft_peak_bin_finder;
    typedef struct {
        int          bin;
        logic [31:0] mag;
        int          cyc;
        bit          found;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t exp_q[$];
    int   err_q[$];
    exp_t e;
    int   ec;

    logic signed [15:0] fr_re [64];
    logic signed [15:0] fr_im [64];

    fft_peak_bin_finder_if #(.BinW(6)) bus ();

    fft_peak_bin_finder #(
        .FFT_SIZE (64)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_in) begin
            if (bus.peak_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_peak_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("peak_bin", bus.peak_bin_out, e.bin);
                    check("peak_mag", bus.peak_mag_out, e.mag);
                    check("peak_cycle", cyc, e.cyc);
`ifdef PEAK_NOISE_GATE_EN
                    check("peak_found", bus.peak_found_out, e.found);
`endif
                end
            end
            if (bus.frame_err_out) begin
                if (err_q.size() == 0) begin
                    check("unexpected_frame_err", 1, 0);
                end else begin
                    ec = err_q.pop_front();
                    check("frame_err_cycle", cyc, ec);
                end
            end
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < 64; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            bus.fft_ce_in   = 1'b0;
            bus.fft_sync_in = 1'b0;
        end
    endtask

    // Drives nbins samples starting at bin 0; gap cycles of ce=0 (with junk and
    // sync high) follow every sample. A full frame queues its expected result.
    task automatic run_frame(input int nbins, input int gap, input bit err_at_sync,
                             input int eb, input logic [31:0] em, input bit ef);
        exp_t x;
        for (int b = 0; b < nbins; b++) begin
            @(negedge clk_in);
            bus.fft_ce_in     = 1'b1;
            bus.fft_sync_in   = (b == 0);
            bus.fft_result_in = {fr_re[b], fr_im[b]};
            if (b == 0 && err_at_sync) err_q.push_back(cyc + 1);
            if (b == 63) begin
                x = '{eb, em, cyc + 2, ef};
                exp_q.push_back(x);
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk_in);
                bus.fft_ce_in     = 1'b0;
                bus.fft_sync_in   = 1'b1;
                bus.fft_result_in = 32'h7fff_7fff;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, bus.peak_valid_out, 0);
        check({tag, "_bin"}, bus.peak_bin_out, 0);
        check({tag, "_mag"}, bus.peak_mag_out, 0);
        check({tag, "_err"}, bus.frame_err_out, 0);
`ifdef PEAK_NOISE_GATE_EN
        check({tag, "_found"}, bus.peak_found_out, 0);
`endif
    endtask

    initial begin
        bus.fft_ce_in     = 1'b0;
        bus.fft_sync_in   = 1'b0;
        bus.fft_result_in = '0;
        repeat (3) @(negedge clk_in);
        check_outputs_zero("reset");
        rst_in = 1'b1;
        idle(3);

        // Single tone at bin 13: 300^2 + 400^2.
        clear_frame();
        fr_re[13] = 16'sd300;
        fr_im[13] = 16'sd400;
        run_frame(64, 0, 0, 13, 32'd250000, 1);
        idle(5);

        // Huge DC is outside the window; tie between bins 5 and 9 goes to 5.
        clear_frame();
        fr_re[0] = 16'sh7fff;
        fr_re[5] = 16'sd100;
        fr_re[9] = 16'sd100;
        run_frame(64, 0, 0, 5, 32'd10000, 1);
        idle(5);

        // Early sync: frame A's large bin 10 must not leak into frame B.
        clear_frame();
        fr_re[10] = 16'sd1000;
        run_frame(20, 0, 0, 0, 0, 0);
        clear_frame();
        fr_re[7] = 16'sd50;
        run_frame(64, 0, 1, 7, 32'd2500, 1);
        idle(5);

        // Sparse ce, most negative value in both halves.
        clear_frame();
        fr_re[31] = -16'sd32768;
        fr_im[31] = -16'sd32768;
        run_frame(64, 2, 0, 31, 32'h8000_0000, 1);
        idle(5);

        // Back-to-back frames, then reset partway into a third.
        clear_frame();
        fr_re[3] = 16'sd10;
        fr_im[3] = 16'sd10;
        run_frame(64, 0, 0, 3, 32'd200, 0);
        clear_frame();
        fr_im[29] = 16'sd30;
        run_frame(64, 0, 0, 29, 32'd900, 0);
        clear_frame();
        fr_re[5] = 16'sd500;
        run_frame(40, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        rst_in          = 1'b0;
        bus.fft_ce_in   = 1'b0;
        bus.fft_sync_in = 1'b0;
        @(negedge clk_in);
        check_outputs_zero("midframe_reset");
        idle(2);
        rst_in = 1'b1;
        // Non-sync samples after reset must be ignored, not finish the old frame.
        for (int i = 0; i < 70; i++) begin
            @(negedge clk_in);
            bus.fft_ce_in     = 1'b1;
            bus.fft_sync_in   = 1'b0;
            bus.fft_result_in = 32'h1234_5678;
        end
        idle(5);

`ifdef PEAK_NOISE_GATE_EN
        clear_frame();
        fr_re[4] = 16'sd30;
        run_frame(64, 0, 0, 4, 32'd900, 0);
        clear_frame();
        fr_re[6] = 16'sd50;
        run_frame(64, 0, 0, 6, 32'd2500, 1);
        idle(5);
`endif

        idle(10);
        check("pending_results", exp_q.size(), 0);
        check("pending_errors", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_peak_bin_finder.md
# fft_peak_bin_finder

Streaming peak-bin detector between the FFT core and the Doppler velocity calculator. Consumes one complex FFT output per clock-enable, computes squared magnitude, and tracks the strongest bin in a configurable positive-frequency search window. At frame end it emits the winning bin index and its magnitude as a one-cycle result pulse. The result drives the Doppler calculator's `peak_frequency` and `start_calc` inputs, which need a bin index rather than a raw FFT real part.

## Interface
- `FFT_SIZE`, 1024: points per FFT frame; power of two, ≥ 8.
- `MIN_BIN`, 1: first bin searched; default excludes DC.
- `MAX_BIN`, `FFT_SIZE/2-1`: last bin searched; `MIN_BIN ≤ MAX_BIN < FFT_SIZE`.
- `clk_in`  input  1  system clock.
- `rst_in`  input  1  reset, synchronous, active-low.
- `fft_ce_in`  input  1  FFT clock-enable; one output sample is valid on each high cycle.
- `fft_sync_in`  input  1  first sample (bin 0) of a frame; meaningful only when `fft_ce_in` is high.
- `fft_result_in`  input  32  `{real[31:16], imag[15:0]}`, both signed two's complement.
- `peak_valid_out`  output  1  one-cycle pulse when a frame result is available.
- `peak_bin_out`  output  `$clog2(FFT_SIZE)`  winning bin index.
- `peak_mag_out`  output  32  winning magnitude, `re²+im²`, unsigned.
- `frame_err_out`  output  1  one-cycle pulse when a malformed frame is discarded.

## Operation
- FSM states:
  - `WAIT_SYNC`: entered from reset; ignores samples.
  - `ACCUM`: frame in progress.
- Transitions:
  - `WAIT_SYNC` → `ACCUM` on `ce && sync`. That sample is bin 0.
  - In `ACCUM`, each `ce` advances the bin counter by 1.
  - The sample at bin `FFT_SIZE-1` closes the frame and returns the FSM to `WAIT_SYNC`.
- Early sync: `ce && sync` in `ACCUM` with counter < `FFT_SIZE-1`.
  - Partial frame is discarded; no result is emitted.
  - `frame_err_out` pulses.
  - This sample becomes bin 0 of a new frame; FSM stays in `ACCUM`.
- Samples in `WAIT_SYNC` without sync are ignored silently.
- Magnitude arithmetic:
  - Compute `re*re + im*im` with signed 16×16 multiplies; each product is ≤ 2^30.
  - The sum is ≤ 2^31 and is held as 32-bit unsigned. No saturation is needed.
  - `-32768²` counts as 2^30.
- Search rules:
  - Only bins in `[MIN_BIN, MAX_BIN]` take part.
  - The first in-window bin loads the running max unconditionally, so an all-zero frame yields `peak_bin_out = MIN_BIN` and `peak_mag_out = 0`.
  - Later bins replace the running max only if strictly greater; on a tie the lowest bin wins.
- Outputs:
  - `peak_bin_out` and `peak_mag_out` update only with `peak_valid_out`, then hold until the next result.
- Reset values: `peak_valid_out=0`, `peak_bin_out=0`, `peak_mag_out=0`, `frame_err_out=0`. FSM goes to `WAIT_SYNC`; counter and running max are cleared.

## Timing
- Two-stage pipeline, clocked every cycle (not gated by ce), with a valid bit per stage:
  - S1 registers the magnitude, bin index and last flag.
  - S2 runs the compare/update.
- `peak_valid_out` goes high exactly 2 clocks after the ce cycle that carries bin `FFT_SIZE-1`.
- `frame_err_out` goes high 1 clock after the offending sync.
- Back-to-back frames at ce=1 every cycle are supported: the last bin of frame k may be followed immediately by sync of frame k+1. Frame k's result is not disturbed by frame k+1's first in-window compare.
- Gaps in ce may occur anywhere; the result depends only on the ce-qualified samples.
- Reset mid-frame clears in-flight pipeline valid bits; no result and no error are emitted for that frame.

## Configuration
- `PEAK_NOISE_GATE_EN`
  - Defined: adds parameter `MIN_PEAK_MAG` (default 1024) and output `peak_found_out` (1 bit, reset 0, registered with `peak_valid_out`). `peak_found_out` is high iff `peak_mag_out ≥ MIN_PEAK_MAG`. Bin and magnitude outputs are reported regardless.
  - Undefined: no extra parameter or port; behaviour is exactly as above.

## Structure
- Package `sonic_fft_pkg` holds:
  - `localparam FFT_SIZE_DEFAULT = 1024`
  - `typedef logic [31:0] fft_mag_t`
  - `typedef struct packed {logic signed [15:0] re, im;} fft_cplx_t`
  - helper `function bin_width(int n)` returning `$clog2(n)`.
- One sub-module, `fft_mag_sq`: the registered S1 stage. It takes `fft_cplx_t` and a valid bit and produces `fft_mag_t` with valid and one cycle of latency, and passes the bin index and last flag through as sideband.
- The FSM, bin counter, window compare and output registers live in the top module.

## Test plan
Bench uses `FFT_SIZE=64` and default window 1..31.
1. Single tone: bin 13 = `{16'd300, 16'd400}`, all others 0, ce=1 every cycle → `peak_valid_out` 2 clocks after bin 63, `peak_bin_out=13`, `peak_mag_out=250000`.
2. DC exclusion and tie: bin 0 = `{16'h7FFF, 0}`, bins 5 and 9 = `{100, 0}` → `peak_bin_out=5`, `peak_mag_out=10000`.
3. Early sync: sync at bin 20 of frame A, then a full frame B with peak at bin 7 → `frame_err_out` pulses 1 clock after the sync, only one `peak_valid_out` is emitted, and it reports bin 7.
4. Sparse ce with extreme input: ce high every 3rd cycle, bin 31 = `{-32768, -32768}` → `peak_bin_out=31`, `peak_mag_out=32'h8000_0000`.
5. Back-to-back frames, then reset:
   - Frames with peaks at bins 3 and 29 → two `peak_valid_out` pulses exactly 64 ce-cycles apart, reporting 3 then 29.
   - Assert `rst_in=0` at bin 40 of a third frame → no further `peak_valid_out`, and all outputs read 0.
6. Gate (`PEAK_NOISE_GATE_EN` defined): peak magnitude 900 → `peak_found_out=0`; peak magnitude 2500 → `peak_found_out=1`.
